// File: rtl/vector_pkg.sv
// vector_pkg: shared constants and types for the vector drawing path.
//   ADR_*       image ROM start addresses for fixed sprites
//   X_BASE1..3  horizontal positions of the three bases
//   Y_BASE      common vertical position of the bases
//   draw_state_t  draw_scheduler state encoding
//   base_x()    maps a base number (0..2) to its X position
package vector_pkg;

  localparam logic [15:0] ADR_CURSOR     = 16'h0010;
  localparam logic [15:0] ADR_BASE       = 16'h0400;
  localparam logic [15:0] ADR_BASE_NUKED = 16'h0480;

  localparam logic [7:0] X_BASE1 = 8'd32;
  localparam logic [7:0] X_BASE2 = 8'd128;
  localparam logic [7:0] X_BASE3 = 8'd224;
  localparam logic [7:0] Y_BASE  = 8'd230;

  // Slot index value that means "all slots visited".
  localparam logic [2:0] LAST_SLOT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } draw_state_t;

  function automatic logic [7:0] base_x(input logic [1:0] n);
    case (n)
      2'd0:    base_x = X_BASE1;
      2'd1:    base_x = X_BASE2;
      default: base_x = X_BASE3;
    endcase
  endfunction

endpackage

// File: rtl/draw_watchdog.sv
// draw_watchdog: bounds how long the scheduler waits for obj_done.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the counter (asserted on the cycle that enters WAIT)
//   enable   : count this cycle (high in every WAIT cycle)
//   expire   : high on the enabled cycle where the count equals TIMEOUT-1,
//              i.e. the TIMEOUT-th WAIT cycle
module draw_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame walker over the 7 drawable slots
// (0 cursor, 1-3 enemies, 4-6 bases). On frame_start the game state is
// snapshotted; each visible slot is then issued as one command and the
// scheduler waits for obj_done (or a watchdog timeout) before moving on.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   frame_start            one-cycle pulse that begins a frame
//   xcursor, ycursor       cursor position
//   xenemyN, yenemyN       enemy N position (N = 1..3)
//   spawn_enemyN           enemy N visible
//   adr_enemyN             enemy N sprite start address
//   baseN_nuked            base N destroyed
//   cmd_valid/cmd_ready    command handshake to the vector engine
//   cmd_adr, cmd_x, cmd_y  command payload
//   obj_done               engine finished current object (pulse)
//   busy                   frame in progress (any state but IDLE)
//   frame_done             one-cycle pulse in the FINISH cycle
//   frame_overrun          pulse the cycle after a frame_start seen while busy
//   timeout_err            pulse the cycle after a slot is abandoned
//   dbg_state              current FSM state (draw_state_t encoding)
//
// Command channel: a command transfers on a cycle where cmd_valid and
// cmd_ready are both high. Once cmd_valid rises it stays high, with
// cmd_adr/cmd_x/cmd_y unchanged, until that transfer (only rst drops it).
module draw_scheduler
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH    = 8,
  parameter int ADDRESSWIDTH = 16,
  parameter int TIMEOUT      = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [OUT_WIDTH-1:0]    xcursor,
  input  logic [OUT_WIDTH-1:0]    ycursor,
  input  logic [OUT_WIDTH-1:0]    xenemy1,
  input  logic [OUT_WIDTH-1:0]    yenemy1,
  input  logic [OUT_WIDTH-1:0]    xenemy2,
  input  logic [OUT_WIDTH-1:0]    yenemy2,
  input  logic [OUT_WIDTH-1:0]    xenemy3,
  input  logic [OUT_WIDTH-1:0]    yenemy3,
  input  logic                    spawn_enemy1,
  input  logic                    spawn_enemy2,
  input  logic                    spawn_enemy3,
  input  logic [ADDRESSWIDTH-1:0] adr_enemy1,
  input  logic [ADDRESSWIDTH-1:0] adr_enemy2,
  input  logic [ADDRESSWIDTH-1:0] adr_enemy3,
  input  logic                    base1_nuked,
  input  logic                    base2_nuked,
  input  logic                    base3_nuked,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDRESSWIDTH-1:0] cmd_adr,
  output logic [OUT_WIDTH-1:0]    cmd_x,
  output logic [OUT_WIDTH-1:0]    cmd_y,
  input  logic                    obj_done,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_overrun,
  output logic                    timeout_err,
  output logic [2:0]              dbg_state
);

  draw_state_t state, state_next;
  logic [2:0]  idx;

  // Frame snapshot
  logic [OUT_WIDTH-1:0]    snap_xc, snap_yc;
  logic [OUT_WIDTH-1:0]    snap_xe  [3];
  logic [OUT_WIDTH-1:0]    snap_ye  [3];
  logic [ADDRESSWIDTH-1:0] snap_adr [3];
  logic [2:0]              snap_sp;
  logic [2:0]              snap_nk;

  // Current slot decode
  logic                    slot_vis;
  logic [ADDRESSWIDTH-1:0] slot_adr;
  logic [OUT_WIDTH-1:0]    slot_x, slot_y;
  logic [1:0]              ei, bi;

  // FSM control strobes
  logic take_snap, idx_clr, idx_inc, load_cmd, wd_clear, to_pulse;
  logic wd_expire;

  // Enemy slots are 1..3 -> enemy 0..2; base slots are 4..6 -> base 0..2,
  // which is just the low two bits of the index.
  assign ei = idx[1:0] - 2'd1;
  assign bi = idx[1:0];

  always_comb begin
    slot_vis = 1'b0;
    slot_adr = '0;
    slot_x   = '0;
    slot_y   = '0;
    case (idx)
      3'd0: begin
        slot_vis = 1'b1;
        slot_adr = ADDRESSWIDTH'(ADR_CURSOR);
        slot_x   = snap_xc;
        slot_y   = snap_yc;
      end
      3'd1, 3'd2, 3'd3: begin
        slot_vis = snap_sp[ei];
        slot_adr = snap_adr[ei];
        slot_x   = snap_xe[ei];
        slot_y   = snap_ye[ei];
      end
      3'd4, 3'd5, 3'd6: begin
        slot_vis = 1'b1;
        slot_adr = snap_nk[bi] ? ADDRESSWIDTH'(ADR_BASE_NUKED) : ADDRESSWIDTH'(ADR_BASE);
        slot_x   = OUT_WIDTH'(base_x(bi));
        slot_y   = OUT_WIDTH'(Y_BASE);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    take_snap  = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    load_cmd   = 1'b0;
    wd_clear   = 1'b0;
    to_pulse   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_next = ST_SELECT;
          take_snap  = 1'b1;
          idx_clr    = 1'b1;
        end
      end
      ST_SELECT: begin
        if (idx == LAST_SLOT) begin
          state_next = ST_FINISH;
        end else if (slot_vis) begin
          state_next = ST_ISSUE;
          load_cmd   = 1'b1;
        end else begin
          idx_inc = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_next = ST_WAIT;
          wd_clear   = 1'b1;
        end
      end
      ST_WAIT: begin
        // A completion arriving on the expiry cycle counts as success.
        if (obj_done) begin
          state_next = ST_SELECT;
          idx_inc    = 1'b1;
        end else if (wd_expire) begin
          state_next = ST_SELECT;
          idx_inc    = 1'b1;
          to_pulse   = 1'b1;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      cmd_adr       <= '0;
      cmd_x         <= '0;
      cmd_y         <= '0;
      timeout_err   <= 1'b0;
      frame_overrun <= 1'b0;
      snap_xc       <= '0;
      snap_yc       <= '0;
      snap_sp       <= '0;
      snap_nk       <= '0;
      for (int i = 0; i < 3; i++) begin
        snap_xe[i]  <= '0;
        snap_ye[i]  <= '0;
        snap_adr[i] <= '0;
      end
    end else begin
      state         <= state_next;
      timeout_err   <= to_pulse;
      frame_overrun <= frame_start && (state != ST_IDLE);
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + 3'd1;
      end
      if (load_cmd) begin
        cmd_adr <= slot_adr;
        cmd_x   <= slot_x;
        cmd_y   <= slot_y;
      end
      if (take_snap) begin
        snap_xc     <= xcursor;
        snap_yc     <= ycursor;
        snap_xe[0]  <= xenemy1;
        snap_xe[1]  <= xenemy2;
        snap_xe[2]  <= xenemy3;
        snap_ye[0]  <= yenemy1;
        snap_ye[1]  <= yenemy2;
        snap_ye[2]  <= yenemy3;
        snap_adr[0] <= adr_enemy1;
        snap_adr[1] <= adr_enemy2;
        snap_adr[2] <= adr_enemy3;
        snap_sp     <= {spawn_enemy3, spawn_enemy2, spawn_enemy1};
        snap_nk     <= {base3_nuked, base2_nuked, base1_nuked};
      end
    end
  end

  draw_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (state == ST_WAIT),
    .expire (wd_expire)
  );

  assign cmd_valid  = (state == ST_ISSUE);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_FINISH);
  assign dbg_state  = state;

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: exercises draw_scheduler with a small engine model
// (accept + delayed obj_done) and a frame-level reference model that lists
// the commands a snapshot must produce and the cycle frame_done must land on.
module tb_draw_scheduler;
  import vector_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, frame_start, cmd_ready, obj_done;
  logic [7:0]  xcursor, ycursor, xenemy1, yenemy1, xenemy2, yenemy2, xenemy3, yenemy3;
  logic        spawn_enemy1, spawn_enemy2, spawn_enemy3;
  logic [15:0] adr_enemy1, adr_enemy2, adr_enemy3;
  logic        base1_nuked, base2_nuked, base3_nuked;
  logic        cmd_valid, busy, frame_done, frame_overrun, timeout_err;
  logic [15:0] cmd_adr;
  logic [7:0]  cmd_x, cmd_y;
  logic [2:0]  dbg_state;

  draw_scheduler #(.OUT_WIDTH(8), .ADDRESSWIDTH(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .xcursor(xcursor), .ycursor(ycursor),
    .xenemy1(xenemy1), .yenemy1(yenemy1), .xenemy2(xenemy2), .yenemy2(yenemy2),
    .xenemy3(xenemy3), .yenemy3(yenemy3),
    .spawn_enemy1(spawn_enemy1), .spawn_enemy2(spawn_enemy2), .spawn_enemy3(spawn_enemy3),
    .adr_enemy1(adr_enemy1), .adr_enemy2(adr_enemy2), .adr_enemy3(adr_enemy3),
    .base1_nuked(base1_nuked), .base2_nuked(base2_nuked), .base3_nuked(base3_nuked),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .obj_done(obj_done), .busy(busy),
    .frame_done(frame_done), .frame_overrun(frame_overrun),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  // game state that the next frame_start will present
  logic [7:0]  g_xc, g_yc;
  logic [7:0]  g_xe[3], g_ye[3];
  logic [15:0] g_adr[3];
  logic        g_sp[3], g_nk[3];

  // engine model knobs and observations
  int  done_delay = 3;   // 0 selects a random delay per object
  bit  done_en = 1'b1;
  bit  rand_ready = 1'b0;
  bit  pend = 1'b0;
  int  dcnt = 0;
  int  n_done = 0, n_ovr = 0, n_to = 0;
  int  last_done_cyc = 0, last_to_cyc = 0, last_hs_cyc = 0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_cmd = '0;

  // ---------------- engine model / monitor (negedge) ----------------
  initial begin
    obj_done = 1'b0;
    forever begin
      @(negedge clk);
      obj_done = 1'b0;
      if (pend) begin
        dcnt--;
        if (dcnt <= 0) begin
          obj_done = done_en;
          pend = 1'b0;
        end
      end
      if (rst) pend = 1'b0;
      // offered command without transfer last cycle must still be offered, unchanged
      if (prev_valid && !prev_ready && !prev_rst) begin
        checks++;
        if (cmd_valid !== 1'b1 || {cmd_adr, cmd_x, cmd_y} !== prev_cmd) begin
          errors++;
          $display("FAIL cmd_hold got valid=%b cmd=%h want valid=1 cmd=%h",
                   cmd_valid, {cmd_adr, cmd_x, cmd_y}, prev_cmd);
        end
      end
      if (cmd_valid === 1'b1 && cmd_ready && !rst) begin
        got_q.push_back({cmd_adr, cmd_x, cmd_y});
        last_hs_cyc = cyc;
        pend = 1'b1;
        dcnt = (done_delay > 0) ? done_delay : int'($urandom_range(1, 6));
      end
      if (frame_done === 1'b1) begin n_done++; last_done_cyc = cyc; end
      if (frame_overrun === 1'b1) n_ovr++;
      if (timeout_err === 1'b1) begin n_to++; last_to_cyc = cyc; end
      prev_valid = cmd_valid;
      prev_ready = cmd_ready;
      prev_rst   = rst;
      prev_cmd   = {cmd_adr, cmd_x, cmd_y};
    end
  end

  // random backpressure driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- reference model ----------------
  // One command per visible slot in fixed order: cursor, spawned enemies, all bases.
  function automatic void model_frame();
    logic [7:0] xb[3];
    xb[0] = X_BASE1; xb[1] = X_BASE2; xb[2] = X_BASE3;
    exp_q.delete();
    exp_q.push_back({ADR_CURSOR, g_xc, g_yc});
    for (int n = 0; n < 3; n++)
      if (g_sp[n]) exp_q.push_back({g_adr[n], g_xe[n], g_ye[n]});
    for (int n = 0; n < 3; n++)
      exp_q.push_back({g_nk[n] ? ADR_BASE_NUKED : ADR_BASE, xb[n], Y_BASE});
  endfunction

  // With ready held high and obj_done 3 cycles after accept, a visible slot
  // costs 5 cycles (select, issue, 3 wait) and a hidden one 1; plus the
  // first select, the final select and FINISH.
  function automatic int model_done_cyc(int t);
    int v;
    v = 4;
    for (int n = 0; n < 3; n++) if (g_sp[n]) v++;
    return t + 1 + 5 * v + (7 - v) + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rand_game();
    g_xc = 8'($urandom); g_yc = 8'($urandom);
    for (int n = 0; n < 3; n++) begin
      g_xe[n] = 8'($urandom); g_ye[n] = 8'($urandom); g_adr[n] = 16'($urandom);
      g_sp[n] = 1'($urandom_range(0, 1)); g_nk[n] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive_game();
    xcursor = g_xc; ycursor = g_yc;
    xenemy1 = g_xe[0]; yenemy1 = g_ye[0]; adr_enemy1 = g_adr[0]; spawn_enemy1 = g_sp[0];
    xenemy2 = g_xe[1]; yenemy2 = g_ye[1]; adr_enemy2 = g_adr[1]; spawn_enemy2 = g_sp[1];
    xenemy3 = g_xe[2]; yenemy3 = g_ye[2]; adr_enemy3 = g_adr[2]; spawn_enemy3 = g_sp[2];
    base1_nuked = g_nk[0]; base2_nuked = g_nk[1]; base3_nuked = g_nk[2];
  endtask

  // Returns at #1 into the cycle after the frame_start cycle t.
  task automatic start_frame(output int t);
    drive_game();
    got_q.delete();
    @(posedge clk); #1;
    frame_start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input int n_before, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      if (n_done > n_before) ok = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; cmd_ready = 1'b1;
    rand_game(); drive_game();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({busy, cmd_valid, frame_done, frame_overrun, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {busy, cmd_valid, frame_done, frame_overrun, timeout_err});
    end
    checks++;
    if ({cmd_adr, cmd_x, cmd_y} !== 32'h0 || dbg_state !== 3'(ST_IDLE)) begin
      errors++;
      $display("FAIL reset_cmd got cmd=%h state=%0d want cmd=0 state=%0d",
               {cmd_adr, cmd_x, cmd_y}, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_basic();
    int t, n0; bit ok;
    rand_game();
    for (int n = 0; n < 3; n++) begin g_sp[n] = 1'b0; g_nk[n] = 1'b0; end
    cmd_ready = 1'b1; done_delay = 3;
    model_frame();
    n0 = n_done;
    start_frame(t);
    checks++;
    if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_select got busy=%b valid=%b want busy=1 valid=0", busy, cmd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_valid !== 1'b1 || {cmd_adr, cmd_x, cmd_y} !== exp_q[0]) begin
      errors++;
      $display("FAIL basic_first_cmd got valid=%b cmd=%h want valid=1 cmd=%h",
               cmd_valid, {cmd_adr, cmd_x, cmd_y}, exp_q[0]);
    end
    wait_frame(n0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got no frame_done want frame_done"); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_cmd[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (n_done - n0 !== 1 || last_done_cyc !== model_done_cyc(t)) begin
      errors++;
      $display("FAIL basic_done got n=%0d cyc=%0d want n=1 cyc=%0d",
               n_done - n0, last_done_cyc, model_done_cyc(t));
    end
  endtask

  task automatic test_snapshot();
    int t, n0; bit ok;
    rand_game();
    for (int n = 0; n < 3; n++) begin g_sp[n] = 1'b0; g_nk[n] = 1'b0; end
    g_sp[1] = 1'b1; g_xe[1] = 8'd40; g_ye[1] = 8'd100; g_adr[1] = 16'h0200;
    cmd_ready = 1'b1; done_delay = 3;
    model_frame();
    n0 = n_done;
    start_frame(t);
    // these must not reach the running frame
    xenemy2 = 8'd77; yenemy2 = 8'd7; adr_enemy2 = 16'h0BAD;
    spawn_enemy1 = 1'b1; base1_nuked = 1'b1; xcursor = ~g_xc;
    wait_frame(n0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL snap_timeout got no frame_done want frame_done"); end
    checks++;
    if (got_q.size() !== 5) begin
      errors++; $display("FAIL snap_count got %0d want 5", got_q.size());
    end else begin
      checks++;
      if (got_q[1] !== {16'h0200, 8'd40, 8'd100}) begin
        errors++; $display("FAIL snap_enemy2 got %h want %h", got_q[1], {16'h0200, 8'd40, 8'd100});
      end
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL snap_cmd[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (last_done_cyc !== model_done_cyc(t)) begin
      errors++; $display("FAIL snap_done_cyc got %0d want %0d", last_done_cyc, model_done_cyc(t));
    end
  endtask

  task automatic test_backpressure();
    int t, n0, to0, r; bit ok;
    rand_game();
    cmd_ready = 1'b0; done_delay = 3;
    model_frame();
    n0 = n_done; to0 = n_to;
    start_frame(t);
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (cmd_valid !== 1'b1 || n_to !== to0 || got_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_stall got valid=%b timeouts=%0d accepted=%0d want valid=1 timeouts=0 accepted=0",
               cmd_valid, n_to - to0, got_q.size());
    end
    cmd_ready = 1'b1;
    r = cyc;
    @(posedge clk); #1;
    checks++;
    if (got_q.size() !== 1 || last_hs_cyc !== r || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got n=%0d cyc=%0d valid=%b want n=1 cyc=%0d valid=0",
               got_q.size(), last_hs_cyc, cmd_valid, r);
    end
    wait_frame(n0, ok);
    checks++;
    if (!ok || got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_cmd[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int t, n0, to0; bit ok, seen;
    rand_game();
    cmd_ready = 1'b1; done_delay = 3; done_en = 1'b0;
    model_frame();
    n0 = n_done; to0 = n_to;
    start_frame(t);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (n_to > to0) seen = 1'b1;
    end
    done_en = 1'b1;
    checks++;
    if (!seen || last_to_cyc !== t + 3 + TO) begin
      errors++;
      $display("FAIL to_pulse got seen=%b cyc=%0d want seen=1 cyc=%0d", seen, last_to_cyc, t + 3 + TO);
    end
    wait_frame(n0, ok);
    checks++;
    if (!ok || got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL to_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL to_cmd[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (n_to - to0 !== 1 || last_done_cyc !== model_done_cyc(t) + (TO - 3)) begin
      errors++;
      $display("FAIL to_done got n_to=%0d cyc=%0d want n_to=1 cyc=%0d",
               n_to - to0, last_done_cyc, model_done_cyc(t) + (TO - 3));
    end
  endtask

  task automatic test_nuked_overrun();
    int t, n0, o0, dc; bit ok;
    rand_game();
    g_nk[0] = 1'b0; g_nk[1] = 1'b1; g_nk[2] = 1'b0;
    cmd_ready = 1'b1; done_delay = 3;
    model_frame();
    n0 = n_done; o0 = n_ovr;
    start_frame(t);
    dc = model_done_cyc(t);
    while (cyc < t + 10) begin @(posedge clk); #1; end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    while (cyc < dc) begin @(posedge clk); #1; end
    frame_start = 1'b1;  // lands on the frame_done cycle
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    ok = (n_done - n0 == 1);
    checks++;
    if (!ok || n_ovr - o0 !== 2 || busy !== 1'b0 || last_done_cyc !== dc) begin
      errors++;
      $display("FAIL ovr_counts got done=%0d ovr=%0d busy=%b cyc=%0d want done=1 ovr=2 busy=0 cyc=%0d",
               n_done - n0, n_ovr - o0, busy, last_done_cyc, dc);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL ovr_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      checks++;
      if (got_q[got_q.size() - 2] !== {ADR_BASE_NUKED, X_BASE2, Y_BASE}) begin
        errors++;
        $display("FAIL ovr_base2 got %h want %h", got_q[got_q.size() - 2], {ADR_BASE_NUKED, X_BASE2, Y_BASE});
      end
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL ovr_cmd[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int t, n0; bit ok;
    rand_ready = 1'b1; done_delay = 0;
    for (int f = 0; f < 6; f++) begin
      rand_game();
      model_frame();
      n0 = n_done;
      start_frame(t);
      wait_frame(n0, ok);
      checks++;
      if (!ok || got_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d want %0d", f, got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_cmd[%0d] got %h want %h", f, i, got_q[i], exp_q[i]);
        end
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    cmd_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t, n0; bit ok;
    rand_game();
    cmd_ready = 1'b1; done_delay = 8;
    start_frame(t);
    for (int i = 0; i < 50 && got_q.size() == 0; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;  // now in WAIT for the cursor
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0 || dbg_state !== 3'(ST_IDLE)) begin
      errors++;
      $display("FAIL rstmid_state got busy=%b valid=%b state=%0d want busy=0 valid=0 state=%0d",
               busy, cmd_valid, dbg_state, ST_IDLE);
    end
    done_delay = 3;
    rand_game();
    model_frame();
    n0 = n_done;
    start_frame(t);
    wait_frame(n0, ok);
    checks++;
    if (!ok || got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rstmid_count got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_cmd[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (last_done_cyc !== model_done_cyc(t)) begin
      errors++; $display("FAIL rstmid_done_cyc got %0d want %0d", last_done_cyc, model_done_cyc(t));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_backpressure();
    test_timeout();
    test_nuked_overrun();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Frame-level consumer of the game-logic entity state. On each `frame_start` pulse it snapshots cursor, enemy and base state, then issues one draw command per visible object to the vector drawing engine over a valid/ready command channel, waiting for the engine's `obj_done` before moving on. It sits between the game-logic block and the vector draw engine.

## Interface
- `OUT_WIDTH`, 8: coordinate width.
- `ADDRESSWIDTH`, 16: image ROM address width.
- `TIMEOUT`, 4096: maximum cycles to wait for `obj_done` before the slot is abandoned.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse that begins a frame.
- `xcursor`, `ycursor` in OUT_WIDTH: cursor position.
- `xenemyN`, `yenemyN` in OUT_WIDTH, N=1..3: enemy positions.
- `spawn_enemyN` in 1: enemy N is visible.
- `adr_enemyN` in ADDRESSWIDTH: enemy N sprite start address.
- `baseN_nuked` in 1: base N is destroyed.
- `cmd_valid` out 1: command valid.
- `cmd_ready` in 1: engine accepts the command.
- `cmd_adr` out ADDRESSWIDTH: sprite start address.
- `cmd_x`, `cmd_y` out OUT_WIDTH: object offset.
- `obj_done` in 1: engine finished the current object (pulse).
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse at frame end.
- `frame_overrun` out 1: one-cycle pulse when `frame_start` arrives while busy.
- `timeout_err` out 1: one-cycle pulse when a slot is abandoned.

## Operation
- Slot order is fixed, 7 slots: 0 cursor, 1–3 enemies 1–3, 4–6 bases 1–3.
- Snapshot:
  - All inputs are registered on the `frame_start` cycle.
  - Later input changes do not affect the current frame.
- Slot contents:
  - Cursor: address `ADR_CURSOR` at (`xcursor`, `ycursor`). Always drawn.
  - Enemy N: drawn only if the snapshotted `spawn_enemyN`=1. Address `adr_enemyN` at (`xenemyN`, `yenemyN`).
  - Base N: always drawn at (`X_BASEN`, `Y_BASE`). Address is `ADR_BASE_NUKED` if `baseN_nuked`, else `ADR_BASE`.
- State machine:
  - IDLE: `frame_start` → SELECT; slot index = 0.
  - SELECT: invisible slot → increment index and stay in SELECT (1 cycle per skipped slot). Visible slot → ISSUE, loading the `cmd_*` registers. If index = 7 → FINISH.
  - ISSUE: `cmd_valid`=1. On `cmd_valid`&`cmd_ready` → WAIT.
  - WAIT: `obj_done` → index+1, SELECT. Watchdog reaching `TIMEOUT` → `timeout_err` pulse, index+1, SELECT.
  - FINISH: `frame_done` pulse → IDLE.
- `cmd_adr`/`cmd_x`/`cmd_y` are registered and stable while `cmd_valid`=1. `cmd_valid` never drops without a handshake.
- `obj_done` outside WAIT is ignored.
- `frame_start` while not IDLE: ignored and `frame_overrun` pulses. The current frame continues unchanged.
- Watchdog:
  - Counter of width $clog2(TIMEOUT+1).
  - Cleared on entering WAIT; counts every WAIT cycle.
  - Times out on the cycle it equals `TIMEOUT`−1.
  - Does not run in ISSUE; backpressure is unbounded.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values:
  - State IDLE, index 0.
  - `cmd_valid`, `busy`, `frame_done`, `frame_overrun`, `timeout_err` = 0.
  - `cmd_adr`, `cmd_x`, `cmd_y` = 0.
- `frame_start` at cycle t:
  - Snapshot taken and state SELECT at t+1.
  - Cursor `cmd_valid` high at t+2.
- Handshake at cycle h → WAIT at h+1.
- `obj_done` at cycle d:
  - Next SELECT at d+1.
  - Next `cmd_valid` at d+2 if that slot is visible; each skipped slot adds 1 cycle.
- Last slot completes (SELECT reaches index 7) → FINISH the next cycle; `frame_done` is asserted for that FINISH cycle. IDLE follows, and a new `frame_start` is accepted in the cycle after `frame_done`.
- `frame_start` coincident with `frame_done`: overrun, ignored.
- `rst` mid-frame: IDLE next cycle, `cmd_valid` drops immediately regardless of `cmd_ready`, snapshot discarded.

## Structure
- `vector_pkg` holds `ADR_CURSOR`, `ADR_BASE`, `ADR_BASE_NUKED`, `X_BASE1..3`, `Y_BASE`, and a `draw_state_t` enum.
- One sub-module: `draw_watchdog`, containing the timeout counter with clear, enable and expire outputs.
- Slot selection is a combinational mux inside the top level.

## Test plan
- **Basic frame.** Reset, `frame_start`, all spawns 0, no bases nuked, `cmd_ready`=1, `obj_done` 3 cycles after each accept. Required: exactly 4 commands — cursor, then bases 1–3 with `ADR_BASE` — then one `frame_done`.
- **Enemy visibility and snapshot.** `spawn_enemy2`=1, `xenemy2`=8'd40, `yenemy2`=8'd100, `adr_enemy2`=16'h0200. Required: 5 commands, the second is (16'h0200, 40, 100). Changing `xenemy2` after `frame_start` does not change the command.
- **Backpressure.** `cmd_ready`=0 for 20 cycles. Required: `cmd_valid` and `cmd_*` held constant, no `timeout_err`. Accept in the cycle `cmd_ready` rises.
- **Timeout.** `TIMEOUT`=16, `obj_done` never asserted for the cursor. Required: `timeout_err` 16 cycles after entering WAIT, then the next slot is issued and the frame still completes.
- **Nuked base and overrun.** `base2_nuked`=1 and a second `frame_start` mid-frame. Required: base 2 drawn with `ADR_BASE_NUKED`, one `frame_overrun` pulse, a single `frame_done`.
- **Reset mid-frame.** `rst` during WAIT. Required: next cycle `busy`=0 and `cmd_valid`=0, and a fresh frame starts again at the cursor.
